// File: rtl/multicycle_control.sv
// Multi-cycle main/ALU control FSM: FETCH, DECODE, EXEC, MEM and WB with memory ready
// handshakes, a wait-state timeout trap and an illegal-opcode trap.
module multicycle_control #(
  parameter int MEM_TIMEOUT  = 15,
  parameter bit ENABLE_JUMPS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [2:0] imm_type,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic       instr_retired,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_ILL
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] CAUSE_ILL  = 2'b01;
  localparam logic [1:0] CAUSE_TOUT = 2'b10;

  localparam int          CW    = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);
  localparam bit          TOUT_EN = (MEM_TIMEOUT > 0);

  state_e         state_q, state_d;
  cls_e           cls_q, cls_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     cause_q, cause_d;

  cls_e           dec_cls;
  logic           wait_st;
  logic           timeout;

  always_comb begin
    dec_cls = C_ILL;
    case (opcode)
      OP_R:      dec_cls = C_R;
      OP_IALU:   dec_cls = C_IALU;
      OP_LOAD:   dec_cls = C_LOAD;
      OP_STORE:  dec_cls = C_STORE;
      OP_BRANCH: dec_cls = C_BRANCH;
      OP_JAL:    dec_cls = ENABLE_JUMPS ? C_JAL  : C_ILL;
      OP_JALR:   dec_cls = ENABLE_JUMPS ? C_JALR : C_ILL;
      default:   dec_cls = C_ILL;
    endcase
  end

  // The counter holds the number of ready-low cycles already seen in this state;
  // a ready-low cycle that finds it at the limit is the one that traps.
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout = TOUT_EN && wait_st && !mem_ready && (cnt_q == LIMIT);

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        cls_d = dec_cls;
        if (dec_cls == C_ILL) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_BRANCH:        state_d = S_FETCH;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM:    if (mem_ready) state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TOUT;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (TOUT_EN && wait_st && !mem_ready && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // ALU operand controls shared by EXEC and MEM for the registered class.
  logic       ex_alu_src;
  logic [1:0] ex_alu_op;
  logic [2:0] ex_imm;

  always_comb begin
    ex_alu_src = 1'b0;
    ex_alu_op  = 2'b00;
    ex_imm     = IMM_I;
    case (cls_q)
      C_R:      ex_alu_op = 2'b10;
      C_IALU:   begin ex_alu_src = 1'b1; ex_alu_op = 2'b11; ex_imm = IMM_I; end
      C_LOAD:   begin ex_alu_src = 1'b1; ex_alu_op = 2'b00; ex_imm = IMM_I; end
      C_STORE:  begin ex_alu_src = 1'b1; ex_alu_op = 2'b00; ex_imm = IMM_S; end
      C_BRANCH: begin ex_alu_src = 1'b0; ex_alu_op = 2'b01; ex_imm = IMM_B; end
      C_JAL:    ex_imm = IMM_J;
      C_JALR:   begin ex_alu_src = 1'b1; ex_alu_op = 2'b00; ex_imm = IMM_I; end
      default:  ;
    endcase
  end

  // Gated by rst so nothing reaches the datapath while reset is held.
  always_comb begin
    mem_req       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    alu_src       = 1'b0;
    alu_op        = 2'b00;
    imm_type      = 3'b000;
    trap          = 1'b0;
    trap_cause    = 2'b00;
    instr_retired = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          ir_write = mem_ready;
        end
        S_EXEC: begin
          alu_src  = ex_alu_src;
          alu_op   = ex_alu_op;
          imm_type = ex_imm;
          if (cls_q == C_BRANCH) begin
            pc_write      = 1'b1;
            pc_src        = branch_taken ? 2'b01 : 2'b00;
            instr_retired = 1'b1;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_read     = (cls_q == C_LOAD);
          mem_write    = (cls_q == C_STORE);
          alu_src      = ex_alu_src;
          alu_op       = ex_alu_op;
          imm_type     = ex_imm;
          if (cls_q == C_STORE && mem_ready) begin
            pc_write      = 1'b1;
            instr_retired = 1'b1;
          end
        end
        S_WB: begin
          reg_write     = 1'b1;
          pc_write      = 1'b1;
          instr_retired = 1'b1;
          case (cls_q)
            C_LOAD: mem_to_reg = 2'b01;
            C_JAL:  begin mem_to_reg = 2'b10; pc_src = 2'b01; end
            C_JALR: begin mem_to_reg = 2'b10; pc_src = 2'b10; alu_src = 1'b1; end
            default: ;
          endcase
        end
        S_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: each instruction is expanded into an expected per-cycle trace from
// its class and wait counts, then replayed against the DUT and compared every cycle.
module tb_multicycle_control;
  localparam int T = 15;

  logic       clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0, mem_ready = 1'b0;

  logic mem_req, mem_read, mem_write, mem_addr_sel, ir_write, pc_write, reg_write;
  logic alu_src, trap, instr_retired;
  logic [1:0] pc_src, mem_to_reg, alu_op, trap_cause;
  logic [2:0] imm_type, state;

  logic n_mem_req, n_mem_read, n_mem_write, n_mem_addr_sel, n_ir_write, n_pc_write, n_reg_write;
  logic n_alu_src, n_trap, n_instr_retired;
  logic [1:0] n_pc_src, n_mem_to_reg, n_alu_op, n_trap_cause;
  logic [2:0] n_imm_type, n_state;

  multicycle_control #(.MEM_TIMEOUT(T), .ENABLE_JUMPS(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .imm_type(imm_type),
    .trap(trap), .trap_cause(trap_cause), .instr_retired(instr_retired), .state(state));

  multicycle_control #(.MEM_TIMEOUT(T), .ENABLE_JUMPS(1'b0)) dut_nj (
    .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .mem_read(n_mem_read), .mem_write(n_mem_write),
    .mem_addr_sel(n_mem_addr_sel), .ir_write(n_ir_write), .pc_write(n_pc_write),
    .pc_src(n_pc_src), .reg_write(n_reg_write), .mem_to_reg(n_mem_to_reg),
    .alu_src(n_alu_src), .alu_op(n_alu_op), .imm_type(n_imm_type), .trap(n_trap),
    .trap_cause(n_trap_cause), .instr_retired(n_instr_retired), .state(n_state));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_read, mem_write, mem_addr_sel, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [2:0] imm_type;
    logic       trap;
    logic [1:0] trap_cause;
    logic       instr_retired;
    logic [2:0] state;
  } outs_t;

  typedef struct {
    logic       rdy, tkn, rstv;
    logic [6:0] op;
    outs_t      e;
  } cyc_t;

  localparam logic [6:0] R = 7'b0110011, IA = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  cyc_t       tr[$];
  outs_t      exp_o, act;
  bit         chk = 1'b0;
  bit         trapped = 1'b0;
  logic [6:0] cur_op = 7'd0;
  int         tests = 0, fails = 0;

  assign act = {mem_req, mem_read, mem_write, mem_addr_sel, ir_write, pc_write, pc_src,
                reg_write, mem_to_reg, alu_src, alu_op, imm_type, trap, trap_cause,
                instr_retired, state};

  always @(negedge clk) begin
    if (chk) begin
      tests++;
      if (act !== exp_o) begin
        fails++;
        $display("FAIL cycle_outputs t=%0t op=%b actual=%h required=%h", $time, opcode, act, exp_o);
      end
    end
  end

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // 0 R, 1 IALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 illegal
  function automatic int cls_of(logic [6:0] op);
    case (op)
      R: return 0;  IA: return 1;  LD: return 2;  ST: return 3;  BR: return 4;
      JAL: return 5;  JALR: return 6;
      default: return 7;
    endcase
  endfunction

  task automatic check(string name, int a, int r);
    tests++;
    if (a != r) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, a, r);
    end
  endtask

  task automatic push(bit r, bit t, bit rs, outs_t e);
    cyc_t x;
    x.rdy = r; x.tkn = t; x.rstv = rs; x.op = cur_op; x.e = e;
    tr.push_back(x);
  endtask

  task automatic trap_cycles(logic [1:0] cause);
    outs_t e = '0;
    e.trap = 1'b1; e.trap_cause = cause; e.state = 3'd5;
    repeat (3) push(rb(), rb(), 1'b0, e);
    trapped = 1'b1;
  endtask

  // w ready-low cycles; more than T of them means a bus-timeout trap after T+1 low cycles.
  task automatic waits(int w, outs_t base, output bit to);
    to = 1'b0;
    if (w > T) begin
      for (int i = 0; i <= T; i++) push(1'b0, rb(), 1'b0, base);
      trap_cycles(2'b10);
      to = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(1'b0, rb(), 1'b0, base);
    end
  endtask

  task automatic do_reset(int n);
    repeat (n) push(rb(), rb(), 1'b1, '0);
  endtask

  task automatic instr(logic [6:0] op, int fw, int mw, bit bt);
    int c = cls_of(op);
    outs_t e, base, ex;
    bit to;
    cur_op = op;
    base = '0; base.mem_req = 1'b1; base.mem_read = 1'b1; base.state = 3'd0;
    waits(fw, base, to);
    if (to) return;
    e = base; e.ir_write = 1'b1;
    push(1'b1, rb(), 1'b0, e);
    e = '0; e.state = 3'd1;
    push(rb(), rb(), 1'b0, e);
    if (c == 7) begin trap_cycles(2'b01); return; end
    ex = '0;
    case (c)
      0: ex.alu_op = 2'b10;
      1: begin ex.alu_src = 1'b1; ex.alu_op = 2'b11; ex.imm_type = 3'b000; end
      2: begin ex.alu_src = 1'b1; ex.imm_type = 3'b000; end
      3: begin ex.alu_src = 1'b1; ex.imm_type = 3'b001; end
      4: begin ex.alu_op = 2'b01; ex.imm_type = 3'b010; end
      5: ex.imm_type = 3'b100;
      default: begin ex.alu_src = 1'b1; ex.imm_type = 3'b000; end
    endcase
    e = ex; e.state = 3'd2;
    if (c == 4) begin
      e.pc_write = 1'b1; e.pc_src = bt ? 2'b01 : 2'b00; e.instr_retired = 1'b1;
      push(rb(), bt, 1'b0, e);
      return;
    end
    push(rb(), rb(), 1'b0, e);
    if (c == 2 || c == 3) begin
      base = ex; base.state = 3'd3; base.mem_req = 1'b1; base.mem_addr_sel = 1'b1;
      base.mem_read = (c == 2); base.mem_write = (c == 3);
      waits(mw, base, to);
      if (to) return;
      e = base;
      if (c == 3) begin e.pc_write = 1'b1; e.instr_retired = 1'b1; end
      push(1'b1, rb(), 1'b0, e);
      if (c == 3) return;
    end
    e = '0; e.state = 3'd4; e.reg_write = 1'b1; e.pc_write = 1'b1; e.instr_retired = 1'b1;
    e.mem_to_reg = (c == 2) ? 2'b01 : (c >= 5) ? 2'b10 : 2'b00;
    e.pc_src     = (c == 5) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00;
    if (c == 6) e.alu_src = 1'b1;
    push(rb(), rb(), 1'b0, e);
  endtask

  task automatic play();
    cyc_t c;
    while (tr.size() > 0) begin
      c = tr.pop_front();
      @(posedge clk);
      #1;
      rst = c.rstv; mem_ready = c.rdy; branch_taken = c.tkn; opcode = c.op; exp_o = c.e;
      chk = 1'b1;
    end
  endtask

  task automatic settle_reset();
    if (trapped) begin do_reset(1); trapped = 1'b0; end
  endtask

  int fw, mw, k, r;
  logic [6:0] op;
  logic [6:0] legal [7];

  initial begin
    legal = '{R, IA, LD, ST, BR, JAL, JALR};
    do_reset(3);
    play();

    // Hand-computed trace shapes pin the model itself.
    instr(R, 0, 0, 1'b0);
    check("model_r_cpi", tr.size(), 4);
    check("model_r_wb_regwrite", int'(tr[3].e.reg_write), 1);
    check("model_r_exec_aluop", int'(tr[2].e.alu_op), 2);
    play();
    instr(LD, 2, 3, 1'b0);
    check("model_load_cpi", tr.size(), 10);
    check("model_load_wb_m2r", int'(tr[9].e.mem_to_reg), 1);
    play();
    instr(BR, 0, 0, 1'b1);
    check("model_br_cpi", tr.size(), 3);
    check("model_br_pcsrc", int'(tr[2].e.pc_src), 1);
    play();
    instr(BR, 0, 0, 1'b0);
    play();

    // Timeout on the limit cycle, and ready arriving exactly on it.
    instr(R, T + 1, 0, 1'b0);
    play();
    check("timeout_trap", int'(trap), 1);
    check("timeout_cause", int'(trap_cause), 2);
    settle_reset();
    instr(R, T, 0, 1'b0);
    instr(ST, 0, T, 1'b0);
    instr(LD, 0, T + 1, 1'b0);
    settle_reset();
    instr(7'b1111111, 0, 0, 1'b0);
    settle_reset();
    play();

    // JAL retires on the default build; the jump-less build traps on it.
    do_reset(2);
    instr(JAL, 0, 0, 1'b0);
    play();
    @(negedge clk);
    check("nojump_jal_state", int'(n_state), 5);
    check("nojump_jal_cause", int'(n_trap_cause), 1);

    // Reset during the MEM phase of a store abandons it.
    instr(ST, 0, 1, 1'b0);
    void'(tr.pop_back());
    do_reset(2);
    instr(IA, 0, 0, 1'b0);
    play();

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 8);
      op = (k < 7) ? legal[k] : 7'($urandom);
      r = $urandom_range(0, 15);
      fw = (r < 10) ? r % 3 : (r < 14) ? $urandom_range(0, T) : (r == 14) ? T : T + 1;
      r = $urandom_range(0, 31);
      mw = (r < 24) ? r % 3 : (r < 30) ? $urandom_range(0, T) : T + 1;
      instr(op, fw, mw, rb());
      settle_reset();
      if ($urandom_range(0, 19) == 0) do_reset(1);
      play();
    end

    @(negedge clk);
    #1;
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
